// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle for the ShiftRows stage: input transaction side
// plus the head-of-buffer output side.
interface shift_rows_pipe_if #(
    parameter int NB = 4
);
    logic            in_valid;
    logic            in_ready;
    logic            in_inv;
    logic [8*NB-1:0] row1;
    logic [8*NB-1:0] row2;
    logic [8*NB-1:0] row3;
    logic [8*NB-1:0] row4;
    logic            out_valid;
    logic            out_ready;
    logic            out_inv;
    logic [8*NB-1:0] row1_out;
    logic [8*NB-1:0] row2_out;
    logic [8*NB-1:0] row3_out;
    logic [8*NB-1:0] row4_out;

    modport master (
        output in_valid, in_inv, row1, row2, row3, row4, out_ready,
        input  in_ready, out_valid, out_inv,
        input  row1_out, row2_out, row3_out, row4_out
    );

    modport slave (
        input  in_valid, in_inv, row1, row2, row3, row4, out_ready,
        output in_ready, out_valid, out_inv,
        output row1_out, row2_out, row3_out, row4_out
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// Registered Rijndael (Inv)ShiftRows for NB = 4/6/8 columns, with a
// 2-entry output buffer so in_ready never depends on out_ready.
module shift_rows_pipe #(
    parameter int NB = 4
) (
    input logic              clk,
    input logic              rst,
    shift_rows_pipe_if.slave bus
);
    localparam int W  = 8 * NB;
    localparam int C3 = (NB == 8) ? 3 : 2;
    localparam int C4 = (NB == 8) ? 4 : 3;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
    endgenerate

    // Column 0 sits in the top byte; inverse rotates the other way.
    function automatic logic [W-1:0] rot(
        input logic [W-1:0] x,
        input int           c,
        input logic         inv
    );
        logic [W-1:0] y;
        int           s;
        y = '0;
        for (int j = 0; j < NB; j++) begin
            s = inv ? (j + NB - c) % NB : (j + c) % NB;
            y[W-1-8*j -: 8] = x[W-1-8*s -: 8];
        end
        return y;
    endfunction

    logic [W-1:0] t_rows [4];
    logic [W-1:0] mem [2][4];
    logic         mem_inv [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    always_comb begin
        t_rows[0] = bus.row1;
        t_rows[1] = rot(bus.row2, 1, bus.in_inv);
        t_rows[2] = rot(bus.row3, C3, bus.in_inv);
        t_rows[3] = rot(bus.row4, C4, bus.in_inv);
    end

    assign bus.in_ready  = !count[1] && !rst;
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_inv  = mem_inv[rd_ptr];
    assign bus.row1_out = mem[rd_ptr][0];
    assign bus.row2_out = mem[rd_ptr][1];
    assign bus.row3_out = mem[rd_ptr][2];
    assign bus.row4_out = mem[rd_ptr][3];

    // Storage is cleared on reset so the idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < 2; e++) begin
                mem_inv[e] <= 1'b0;
                for (int k = 0; k < 4; k++) begin
                    mem[e][k] <= '0;
                end
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                for (int k = 0; k < 4; k++) begin
                    mem[wr_ptr][k] <= t_rows[k];
                end
                mem_inv[wr_ptr] <= bus.in_inv;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench: directed NB=4/8 vectors, backpressure, reset,
// and randomized NB=6 stress against a rotate-based reference model.
module tb_shift_rows_pipe;
    typedef struct packed {
        logic            inv;
        logic [3:0][63:0] r;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    shift_rows_pipe_if #(.NB(4)) b4 ();
    shift_rows_pipe_if #(.NB(6)) b6 ();
    shift_rows_pipe_if #(.NB(8)) b8 ();

    shift_rows_pipe #(.NB(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    shift_rows_pipe #(.NB(6)) u6 (.clk(clk), .rst(rst), .bus(b6));
    shift_rows_pipe #(.NB(8)) u8 (.clk(clk), .rst(rst), .bus(b8));

    task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int offs(int nb, int r);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return (nb == 8) ? 3 : 2;
            default: return (nb == 8) ? 4 : 3;
        endcase
    endfunction

    // Byte rotate of an nb-byte row: left by C forward, left by nb-C inverse.
    function automatic logic [63:0] ref_rot(logic [63:0] x, int nb, int r, logic inv);
        int          c;
        int          k;
        int          w;
        logic [63:0] m;
        c = offs(nb, r);
        k = inv ? (nb - c) % nb : c;
        w = 8 * nb;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((x << (8 * k)) | (x >> (w - 8 * k))) & m;
    endfunction

    function automatic txn_t model(txn_t t, int nb);
        txn_t o;
        o.inv = t.inv;
        for (int r = 0; r < 4; r++) o.r[r] = ref_rot(t.r[r], nb, r, t.inv);
        return o;
    endfunction

    function automatic txn_t rand_txn(int nb);
        txn_t        t;
        logic [63:0] m;
        m = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        t.inv = 1'($urandom_range(0, 1));
        for (int r = 0; r < 4; r++) t.r[r] = {$urandom, $urandom} & m;
        return t;
    endfunction

    function automatic txn_t head4();
        txn_t h;
        h.inv  = b4.out_inv;
        h.r[0] = {32'd0, b4.row1_out};
        h.r[1] = {32'd0, b4.row2_out};
        h.r[2] = {32'd0, b4.row3_out};
        h.r[3] = {32'd0, b4.row4_out};
        return h;
    endfunction

    function automatic txn_t head6();
        txn_t h;
        h.inv  = b6.out_inv;
        h.r[0] = {16'd0, b6.row1_out};
        h.r[1] = {16'd0, b6.row2_out};
        h.r[2] = {16'd0, b6.row3_out};
        h.r[3] = {16'd0, b6.row4_out};
        return h;
    endfunction

    task automatic drive4(logic v, txn_t t);
        b4.in_valid = v;
        b4.in_inv   = t.inv;
        b4.row1     = t.r[0][31:0];
        b4.row2     = t.r[1][31:0];
        b4.row3     = t.r[2][31:0];
        b4.row4     = t.r[3][31:0];
    endtask

    task automatic drive6(logic v, txn_t t);
        b6.in_valid = v;
        b6.in_inv   = t.inv;
        b6.row1     = t.r[0][47:0];
        b6.row2     = t.r[1][47:0];
        b6.row3     = t.r[2][47:0];
        b6.row4     = t.r[3][47:0];
    endtask

    initial begin
        txn_t   t0, t1, bp[3];
        txn_t   q[$];
        txn_t   cur;
        txn_t   hold;
        txn_t   e;
        logic   stall_prev;
        int     sent;
        int     got;
        int     cyc;

        t0 = '0;
        drive4(1'b0, t0);
        drive6(1'b0, t0);
        b8.in_valid = 1'b0; b8.in_inv = 1'b0;
        b8.row1 = '0; b8.row2 = '0; b8.row3 = '0; b8.row4 = '0;
        b4.out_ready = 1'b0; b6.out_ready = 1'b0; b8.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", b4.in_ready, 0);
        check("rst_out_valid", b4.out_valid, 0);
        check("rst_head4", head4(), 0);
        check("rst_out_valid8", b8.out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", b4.in_ready, 1);

        // NB=4 forward then inverse, back to back
        t0.inv = 1'b0;
        t0.r   = {64'h30313233, 64'h20212223, 64'h10111213, 64'h00010203};
        t1.inv = 1'b1;
        t1.r   = {64'h33303132, 64'h22232021, 64'h11121310, 64'h00010203};
        b4.out_ready = 1'b1;
        drive4(1'b1, t0);
        @(negedge clk);
        check("fwd4_valid", b4.out_valid, 1);
        check("fwd4_data", head4(), {1'b0, t1.r});
        drive4(1'b1, t1);
        @(negedge clk);
        check("inv4_valid", b4.out_valid, 1);
        check("inv4_data", head4(), {1'b1, t0.r});
        drive4(1'b0, t0);
        @(negedge clk);
        check("drain4_valid", b4.out_valid, 0);

        // NB=8 forward
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b1;
        b8.row1 = 64'h0001020304050607;
        b8.row2 = 64'h0001020304050607;
        b8.row3 = 64'h0001020304050607;
        b8.row4 = 64'h0001020304050607;
        @(negedge clk);
        b8.in_valid = 1'b0;
        check("fwd8_valid", b8.out_valid, 1);
        check("fwd8_row1", b8.row1_out, 64'h0001020304050607);
        check("fwd8_row2", b8.row2_out, 64'h0102030405060700);
        check("fwd8_row3", b8.row3_out, 64'h0304050607000102);
        check("fwd8_row4", b8.row4_out, 64'h0405060700010203);
        check("fwd8_inv", b8.out_inv, 0);

        // Backpressure on NB=4
        b4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) bp[i] = rand_txn(4);
        drive4(1'b1, bp[0]);
        @(negedge clk);
        drive4(1'b1, bp[1]);
        @(negedge clk);
        drive4(1'b1, bp[2]);
        check("bp_full_ready", b4.in_ready, 0);
        check("bp_head0", head4(), model(bp[0], 4));
        @(negedge clk);
        check("bp_still_full", b4.in_ready, 0);
        check("bp_head0_stable", head4(), model(bp[0], 4));
        b4.out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_pop", b4.in_ready, 1);
        check("bp_head1", head4(), model(bp[1], 4));
        @(negedge clk);
        drive4(1'b0, bp[0]);
        check("bp_valid2", b4.out_valid, 1);
        check("bp_head2", head4(), model(bp[2], 4));
        @(negedge clk);
        check("bp_empty", b4.out_valid, 0);
        b4.out_ready = 1'b0;

        // Randomized NB=6 stress
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; hold = '0;
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            check("occupancy", b6.out_valid, q.size() != 0);
            check("ready_rule", b6.in_ready, q.size() < 2);
            if (stall_prev) check("stall_stable", head6(), hold);
            cur = rand_txn(6);
            drive6((sent < 1000) && ($urandom_range(0, 3) != 0), cur);
            b6.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (b6.out_valid && b6.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("stress_data", head6(), e);
                    got++;
                end
            end
            if (b6.in_valid && b6.in_ready) begin
                q.push_back(model(cur, 6));
                sent++;
            end
            stall_prev = b6.out_valid && !b6.out_ready;
            hold       = head6();
        end
        check("stress_count", got, 1000);

        // Reset with two entries buffered
        @(negedge clk);
        drive6(1'b0, cur);
        b6.out_ready = 1'b1;
        @(negedge clk);
        b6.out_ready = 1'b0;
        drive6(1'b1, rand_txn(6));
        @(negedge clk);
        drive6(1'b1, rand_txn(6));
        @(negedge clk);
        drive6(1'b0, cur);
        check("pre_rst_full", b6.in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", b6.out_valid, 0);
        check("mid_rst_head", head6(), 0);
        check("mid_rst_ready", b6.in_ready, 0);
        rst = 1'b0;
        b6.out_ready = 1'b1;
        @(negedge clk);
        check("rel_rst_ready", b6.in_ready, 1);
        check("rel_rst_valid", b6.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
